// File: rtl/ucode_image_loader.sv
// Microcode image loader: turns a front-end byte stream into CRAM/DRAM write
// strobes and holds the EBOX in reset (holdCROBAR) until a GO command releases it.
module ucode_image_loader #(
  parameter int unsigned CRAM_WIDTH    = 84,
  parameter int unsigned CRAM_ADDR_W   = 11,
  parameter int unsigned DRAM_WIDTH    = 24,
  parameter int unsigned DRAM_ADDR_W   = 9,
  parameter int unsigned RELEASE_DELAY = 10
) (
  input  logic                   clk,
  input  logic                   CROBAR,
  input  logic [7:0]             rxData,
  input  logic                   rxValid,
  output logic                   rxReady,
  output logic                   cramWe,
  output logic [CRAM_ADDR_W-1:0] cramAddr,
  output logic [CRAM_WIDTH-1:0]  cramData,
  output logic                   dramWe,
  output logic [DRAM_ADDR_W-1:0] dramAddr,
  output logic [DRAM_WIDTH-1:0]  dramData,
  output logic                   holdCROBAR,
  output logic                   loadDone,
  output logic                   loadErr
);

  localparam int unsigned CramBytes = (CRAM_WIDTH + 7) / 8;
  localparam int unsigned DramBytes = (DRAM_WIDTH + 7) / 8;
  localparam int unsigned WordW     = (CramBytes > DramBytes ? CramBytes : DramBytes) * 8;
  localparam int unsigned DlyW      = $clog2(RELEASE_DELAY + 1);

  typedef enum logic [3:0] {
    StIdle, StAddrHi, StAddrLo, StCntHi, StCntLo, StData, StWrite, StGoWait, StRun, StErr
  } state_e;

  state_e           state;
  logic             tgt_dram;   // 0: CRAM record, 1: DRAM record
  logic [7:0]       hi_byte;    // staged MSB of address / count
  logic [15:0]      addr;
  logic [15:0]      count;
  logic [7:0]       byte_cnt;
  logic [WordW-1:0] word;
  logic [DlyW-1:0]  dly;

  logic             accept;
  logic [WordW-1:0] word_shift;
  logic [15:0]      full16;
  logic             addr_bad;
  logic [7:0]       last_byte;

  // Byte acceptance is a pure decode of state; reset always blocks it.
  always_comb begin
    rxReady = 1'b0;
    if (!CROBAR) begin
      case (state)
        StIdle, StAddrHi, StAddrLo, StCntHi, StCntLo, StData: rxReady = 1'b1;
        default:                                              rxReady = 1'b0;
      endcase
    end
  end

  // Datapath helpers shared by the FSM.
  always_comb begin
    accept     = rxValid && rxReady;
    word_shift = {word[WordW-9:0], rxData};
    full16     = {hi_byte, rxData};
    addr_bad   = tgt_dram ? (|(full16 >> DRAM_ADDR_W)) : (|(full16 >> CRAM_ADDR_W));
    last_byte  = tgt_dram ? 8'(DramBytes - 1) : 8'(CramBytes - 1);
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state      <= StIdle;
      tgt_dram   <= 1'b0;
      hi_byte    <= '0;
      addr       <= '0;
      count      <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      dly        <= '0;
      cramWe     <= 1'b0;
      cramAddr   <= '0;
      cramData   <= '0;
      dramWe     <= 1'b0;
      dramAddr   <= '0;
      dramData   <= '0;
      holdCROBAR <= 1'b1;
      loadDone   <= 1'b0;
      loadErr    <= 1'b0;
    end else begin
      cramWe <= 1'b0;
      dramWe <= 1'b0;
      case (state)
        StIdle: begin
          if (accept) begin
            case (rxData)
              8'h43: begin tgt_dram <= 1'b0; state <= StAddrHi; end
              8'h44: begin tgt_dram <= 1'b1; state <= StAddrHi; end
              8'h47: begin dly <= '0;        state <= StGoWait; end
              default: begin loadErr <= 1'b1; state <= StErr; end
            endcase
          end
        end
        StAddrHi: if (accept) begin hi_byte <= rxData; state <= StAddrLo; end
        StAddrLo: begin
          if (accept) begin
            if (addr_bad) begin
              loadErr <= 1'b1;
              state   <= StErr;
            end else begin
              addr  <= full16;
              state <= StCntHi;
            end
          end
        end
        StCntHi: if (accept) begin hi_byte <= rxData; state <= StCntLo; end
        StCntLo: begin
          if (accept) begin
            count    <= full16;
            byte_cnt <= '0;
            state    <= (full16 == 16'd0) ? StIdle : StData;
          end
        end
        StData: begin
          if (accept) begin
            word <= word_shift;
            if (byte_cnt == last_byte) begin
              // Strobe lands in the WRITE cycle; high excess bits fall off the slice.
              if (tgt_dram) begin
                dramWe   <= 1'b1;
                dramAddr <= addr[DRAM_ADDR_W-1:0];
                dramData <= word_shift[DRAM_WIDTH-1:0];
              end else begin
                cramWe   <= 1'b1;
                cramAddr <= addr[CRAM_ADDR_W-1:0];
                cramData <= word_shift[CRAM_WIDTH-1:0];
              end
              state <= StWrite;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        StWrite: begin
          // Only the low ADDR_W bits reach the port, so the increment wraps there.
          addr     <= addr + 16'd1;
          count    <= count - 16'd1;
          byte_cnt <= '0;
          state    <= (count == 16'd1) ? StIdle : StData;
        end
        StGoWait: begin
          if (dly == DlyW'(RELEASE_DELAY - 1)) begin
            holdCROBAR <= 1'b0;
            loadDone   <= 1'b1;
            state      <= StRun;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        StRun, StErr: state <= state;
        default: begin
          loadErr <= 1'b1;
          state   <= StErr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_image_loader.sv
// Scoreboard bench for ucode_image_loader: records are built from random or
// fixed words, expected writes are queued, and a negedge monitor checks strobes.
module tb_ucode_image_loader;

  localparam int unsigned RD = 4;

  logic        clk = 1'b0;
  logic        CROBAR = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        rxReady;
  logic        cramWe;
  logic [10:0] cramAddr;
  logic [83:0] cramData;
  logic        dramWe;
  logic [8:0]  dramAddr;
  logic [23:0] dramData;
  logic        holdCROBAR;
  logic        loadDone;
  logic        loadErr;

  ucode_image_loader #(
    .CRAM_WIDTH   (84),
    .CRAM_ADDR_W  (11),
    .DRAM_WIDTH   (24),
    .DRAM_ADDR_W  (9),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk       (clk),
    .CROBAR    (CROBAR),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxReady   (rxReady),
    .cramWe    (cramWe),
    .cramAddr  (cramAddr),
    .cramData  (cramData),
    .dramWe    (dramWe),
    .dramAddr  (dramAddr),
    .dramData  (dramData),
    .holdCROBAR(holdCROBAR),
    .loadDone  (loadDone),
    .loadErr   (loadErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dram;
    int unsigned addr;
    logic [83:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [87:0] tx_words[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write.
  wr_t e;
  always @(negedge clk) begin
    if (cramWe || dramWe) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual cramWe=%0b dramWe=%0b required=none",
                 cramWe, dramWe);
      end else begin
        e = exp_q.pop_front();
        chk("write_target", {94'b0, cramWe, dramWe}, e.dram ? 96'd1 : 96'd2);
        chk("write_addr", e.dram ? 96'(dramAddr) : 96'(cramAddr), 96'(e.addr));
        chk("write_data", e.dram ? 96'(dramData) : 96'(cramData), 96'(e.data));
      end
    end
  end

  // Offer one byte, optionally after a random idle gap; bounded wait for rxReady.
  task automatic send(input logic [7:0] b);
    int n = 0;
    if ($urandom_range(0, 3) == 0) begin
      rxValid = 1'b0;
      @(negedge clk);
    end
    rxData  = b;
    rxValid = 1'b1;
    #1;
    while (!rxReady && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual rxReady=%0b required=1 byte=%0h", rxReady, b);
    end else begin
      @(negedge clk);
    end
    rxValid = 1'b0;
  endtask

  // Reference model: a record writes word i at (addr + i) mod 2^ADDR_W; data is the
  // word's low WIDTH bits taken from the bytes sent MSB first.
  task automatic record(input bit dram, input int unsigned addr, input int unsigned cnt);
    int unsigned nb = dram ? 3 : 11;
    int unsigned aw = dram ? 9 : 11;
    logic [15:0] a16 = addr[15:0];
    logic [15:0] c16 = cnt[15:0];
    logic [95:0] r;
    logic [87:0] d;
    wr_t         w;
    send(dram ? 8'h44 : 8'h43);
    send(a16[15:8]);
    send(a16[7:0]);
    send(c16[15:8]);
    send(c16[7:0]);
    for (int i = 0; i < int'(cnt); i++) begin
      if (tx_words.size() != 0) begin
        d = tx_words.pop_front();
      end else begin
        r = {$urandom(), $urandom(), $urandom()};
        d = r[87:0];
      end
      w.dram = dram;
      w.addr = (addr + i) % (32'd1 << aw);
      w.data = dram ? {60'b0, d[23:0]} : d[83:0];
      exp_q.push_back(w);
      for (int b = int'(nb) - 1; b >= 0; b--) send(d[8*b +: 8]);
    end
  endtask

  // Reset for the given cycles with a byte offered; reset must win.
  task automatic do_reset(input int cycles);
    CROBAR  = 1'b1;
    rxValid = 1'b1;
    rxData  = 8'h43;
    #1;
    chk("reset_blocks_rxready", {95'b0, rxReady}, 96'd0);
    for (int i = 0; i < cycles; i++) @(negedge clk);
    CROBAR  = 1'b0;
    rxValid = 1'b0;
    chk("reset_hold", {95'b0, holdCROBAR}, 96'd1);
    chk("reset_done", {95'b0, loadDone}, 96'd0);
    chk("reset_err", {95'b0, loadErr}, 96'd0);
    chk("reset_we", {94'b0, cramWe, dramWe}, 96'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset(2);
    chk("reset_cram_addr", 96'(cramAddr), 96'd0);
    chk("reset_cram_data", 96'(cramData), 96'd0);
    chk("reset_dram_addr", 96'(dramAddr), 96'd0);
    chk("reset_dram_data", 96'(dramData), 96'd0);
    #1;
    chk("idle_rxready", {95'b0, rxReady}, 96'd1);

    // CRAM wrap from 0x7FF to 0x000, with set excess bits that must be dropped.
    tx_words.push_back({4'hF, {21{4'hA}}});
    tx_words.push_back({4'h3, {21{4'h5}}});
    record(1'b0, 32'h7FF, 2);
    @(negedge clk);
    chk("wrap_back_idle", {95'b0, rxReady}, 96'd1);

    // DRAM single word.
    tx_words.push_back({64'b0, 24'h123456});
    record(1'b1, 32'h005, 1);

    // Zero count: no writes, back to IDLE.
    record(1'b1, 32'h010, 0);
    @(negedge clk);
    chk("zero_cnt_idle", {95'b0, rxReady}, 96'd1);

    // Random records, some placed near the top to exercise wrap.
    for (int k = 0; k < 8; k++) begin
      bit          dr = 1'($urandom_range(0, 1));
      int unsigned top = dr ? 32'h1FF : 32'h7FF;
      int unsigned a = ($urandom_range(0, 2) == 0) ? top - $urandom_range(0, 1)
                                                   : $urandom_range(0, top);
      record(dr, a, $urandom_range(1, 3));
    end
    repeat (3) @(negedge clk);

    // Address out of range for DRAM (bit 9 set).
    send(8'h44);
    send(8'h02);
    send(8'h00);
    #1;
    chk("range_err", {95'b0, loadErr}, 96'd1);
    chk("range_rxready", {95'b0, rxReady}, 96'd0);
    do_reset(1);

    // Bad command byte.
    send(8'h58);
    #1;
    chk("badcmd_err", {95'b0, loadErr}, 96'd1);
    chk("badcmd_rxready", {95'b0, rxReady}, 96'd0);
    repeat (3) @(negedge clk);
    chk("badcmd_hold", {95'b0, holdCROBAR}, 96'd1);
    chk("badcmd_err_sticky", {95'b0, loadErr}, 96'd1);
    do_reset(1);

    // Reset mid-word: 5 of 11 bytes, then reset; nothing may be written.
    send(8'h43); send(8'h00); send(8'h20); send(8'h00); send(8'h01);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    @(negedge clk);
    do_reset(1);
    record(1'b0, 32'h021, 1);
    repeat (3) @(negedge clk);

    // Release timing after 'G'.
    send(8'h47);
    for (int i = 0; i < int'(RD); i++) begin
      chk("go_hold_high", {94'b0, holdCROBAR, loadDone}, 96'd2);
      @(negedge clk);
    end
    chk("go_released", {94'b0, holdCROBAR, loadDone}, 96'd1);
    rxValid = 1'b1;
    rxData  = 8'h43;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("run_no_accept", {95'b0, rxReady}, 96'd0);
      @(negedge clk);
    end
    rxValid = 1'b0;
    CROBAR  = 1'b1;
    @(negedge clk);
    CROBAR  = 1'b0;
    chk("run_reset_hold", {94'b0, holdCROBAR, loadDone}, 96'd2);

    repeat (3) @(negedge clk);
    chk("queue_empty", 96'(exp_q.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucode_image_loader.md
Name: ucode_image_loader

Overview:
- Front-end loader upstream of the KL10 top: consumes a byte stream from the console/front-end link and writes microcode words into CRAM and dispatch words into DRAM.
- Holds the EBOX in reset via holdCROBAR until a GO command arrives.
- Replaces simulation-only memory preloading with a synthesizable path, so the same load sequence runs on hardware.

Parameters:
- CRAM_WIDTH, 84, CRAM word width in bits.
- CRAM_ADDR_W, 11, CRAM address width.
- DRAM_WIDTH, 24, DRAM word width in bits.
- DRAM_ADDR_W, 9, DRAM address width.
- RELEASE_DELAY, 10, cycles holdCROBAR stays high after GO is accepted (min 1).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- CROBAR  in  1  reset: synchronous, active-high.
- rxData  in  8  stream byte.
- rxValid  in  1  rxData valid.
- rxReady  out  1  loader accepts a byte this cycle.
- cramWe  out  1  one-cycle CRAM write strobe.
- cramAddr  out  CRAM_ADDR_W  CRAM write address.
- cramData  out  CRAM_WIDTH  CRAM write data.
- dramWe  out  1  one-cycle DRAM write strobe.
- dramAddr  out  DRAM_ADDR_W  DRAM write address.
- dramData  out  DRAM_WIDTH  DRAM write data.
- holdCROBAR  out  1  reset to EBOX/MBOX; high until load is released.
- loadDone  out  1  high once holdCROBAR has been released.
- loadErr  out  1  sticky protocol error.

Behaviour:
- Clock and reset: one clock `clk`; reset `CROBAR` is synchronous and active-high.
- Reset values: state IDLE, holdCROBAR=1, loadDone=0, loadErr=0, cramWe=dramWe=0, all addr/data outputs 0, byte/word counters 0. rxReady is forced 0 in any cycle with CROBAR=1.
- Byte acceptance: a byte is consumed when rxValid && rxReady. rxReady is a combinational decode of state: 1 in IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA; 0 in WRITE, GO_WAIT, RUN, ERR.
- IDLE command byte:
  - 0x43 'C': target=CRAM, go to ADDR_HI.
  - 0x44 'D': target=DRAM, go to ADDR_HI.
  - 0x47 'G': go to GO_WAIT.
  - Any other byte: go to ERR.
- ADDR_HI, ADDR_LO: 16-bit start address, MSB first. If any bit at or above the target ADDR_W is set, go to ERR after ADDR_LO.
- CNT_HI, CNT_LO: 16-bit word count, MSB first. Count 0 returns to IDLE with no writes; otherwise go to DATA.
- DATA: shifts bytes into the word register MSB first.
  - Bytes per word: ceil(WIDTH/8), i.e. 11 for CRAM and 3 for DRAM.
  - Excess high bits of the first byte are discarded.
  - After the last byte of a word, go to WRITE.
- WRITE (exactly 1 cycle):
  - Target We=1 with the current addr/data; the other target's We stays 0.
  - Next cycle: address += 1 modulo 2^ADDR_W (wraps), count -= 1.
  - Count now 0: go to IDLE. Otherwise: go to DATA with the byte counter cleared.
  - Addr/data outputs hold their last value between writes.
- Write latency: the We pulse occurs the cycle after the last data byte is accepted. The maximum stream rate is therefore 1 byte per cycle, with one stall cycle per word.
- GO_WAIT: count RELEASE_DELAY cycles starting the cycle after 'G' is accepted. holdCROBAR=1 throughout. On expiry go to RUN.
- RUN: holdCROBAR=0, loadDone=1. Terminal state; only CROBAR exits it.
- ERR: loadErr=1, holdCROBAR=1, no further writes. Terminal state until CROBAR.
- Reset mid-operation: a partial word is discarded, no We is issued, all outputs return to reset values in the next cycle, and holdCROBAR reasserts even from RUN.
- Simultaneous CROBAR and rxValid: reset wins and the byte is not consumed.
- Multiple C/D records may precede G, in any order. Later writes to the same address overwrite earlier ones.

Test Plan:
- CRAM wrap: stream 43 07 FF 00 02, then 22 data bytes (word0 = 0x0A...A, word1 = 0x05...5) -> cramWe at cramAddr 0x7FF with word0, then at 0x000 with word1; returns to IDLE and rxReady=1.
- DRAM single word: stream 44 00 05 00 01 12 34 56 -> one dramWe pulse, dramAddr=0x005, dramData=0x123456; cramWe never asserted.
- Zero count and range check: 44 00 10 00 00 -> no writes, back in IDLE. Then 44 02 00 ... (address bit 9 set) -> loadErr=1, rxReady=0.
- Bad command: byte 0x58 in IDLE -> loadErr=1 the next cycle, rxReady=0, holdCROBAR=1 until CROBAR is pulsed.
- Release timing (RELEASE_DELAY=4): 'G' accepted at cycle T -> holdCROBAR=1 through T+4, holdCROBAR=0 and loadDone=1 from T+5; subsequent bytes are not consumed.
- Reset mid-word: CRAM record started, CROBAR pulsed 1 cycle after 5 of 11 data bytes -> no cramWe issued; a fresh 1-word record afterwards writes correctly.
